api_ch_sched: RTL and testbench

//  N-channel round-robin scheduler between the API TX/RX FIFOs and the serial PHY. Per frame: selects
//  one enabled channel (active-low load), streams reg_word_num words, captures the first RX_BLOCK words
//  of each WORK_WORDS chip slot with a channel/chip tag, then idles NOP_CYC cycles. Adds channel-enable

---
 rtl/api_ch_sched.sv | 197 +++++++++++++++++++
 tb/tb_api_ch_sched.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/api_ch_sched.sv
// Round-robin channel scheduler between the API TX/RX FIFOs and the serial PHY.
// Each frame streams reg_word_num words for one enabled channel, then idles NOP_CYC cycles.
module api_ch_sched #(
    parameter int N_CH       = 10,
    parameter int CH_W       = 4,
    parameter int WORK_WORDS = 23,
    parameter int RX_BLOCK   = 11,
    parameter int RX_DEPTH   = 512,
    parameter int MAX_CHIP   = 5,
    parameter int NOP_CYC    = 15,
    parameter int TMR_W      = 28
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             reg_rst,
    input  logic [N_CH-1:0]  reg_ch_en,
    input  logic [8:0]       reg_word_num,
    input  logic [TMR_W-1:0] reg_timeout,
    output logic [1:0]       state,
    output logic             busy,
    input  logic             tx_empty,
    output logic             tx_rd_en,
    input  logic [31:0]      tx_dout,
    output logic             rx_wr_en,
    output logic [31:0]      rx_din,
    input  logic [9:0]       rx_count,
    output logic             phy_mosi_vld,
    output logic [31:0]      phy_mosi_dat,
    input  logic             phy_miso_vld,
    input  logic [31:0]      phy_miso_dat,
    output logic [N_CH-1:0]  load,
    input  logic [N_CH-1:0]  miso_ch,
    output logic             miso_out,
    output logic [CH_W-1:0]  miner_id,
    output logic [3:0]       chip_idx,
    output logic             nonce_hit,
    output logic [CH_W-1:0]  nonce_ch
);
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_WORK = 2'd1, S_NOP = 2'd2} state_t;

    localparam int WI_W  = $clog2(WORK_WORDS);
    localparam int NOP_W = $clog2(NOP_CYC + 1);
    localparam int CHX_W = CH_W + 1;
    localparam logic [WI_W-1:0]  WI_LAST  = WI_W'(WORK_WORDS - 1);
    localparam logic [WI_W-1:0]  WI_RXB   = WI_W'(RX_BLOCK);
    localparam logic [WI_W-1:0]  WI_TAG   = WI_W'(RX_BLOCK - 1);
    localparam logic [WI_W-1:0]  WI_NONCE = WI_W'(RX_BLOCK - 2);
    localparam logic [NOP_W-1:0] NOP_LAST = NOP_W'(NOP_CYC - 1);
    localparam logic [11:0]      RX_NEED  = 12'(RX_BLOCK * MAX_CHIP);
    localparam logic [11:0]      RX_DEP   = 12'(RX_DEPTH);
    localparam logic [CHX_W-1:0] N_CH_L   = CHX_W'(N_CH);

    state_t           r_state, w_state_nx;
    logic [CH_W-1:0]  r_ch_sel, w_ch_nx;
    logic [TMR_W-1:0] r_timer, w_timer_nx;
    logic [8:0]       r_word_cnt, w_word_nx, w_word_inc;
    logic [WI_W-1:0]  r_work_idx, w_widx_nx;
    logic [3:0]       r_chip_idx, w_chip_nx;
    logic [NOP_W-1:0] r_nop_cnt, w_nop_nx;
    logic             r_mosi_vld, w_mosi_nx;
    logic             r_nonce_hit, w_nonce_nx;
    logic [CH_W-1:0]  r_nonce_ch, w_nonce_ch_nx;
    logic             w_busy, w_rx_ok, w_start, w_rx_wr;
    logic [N_CH-1:0]  w_sel_oh;

    // Next enabled channel strictly after cur, wrapping; cur itself if no other is enabled.
    function automatic logic [CH_W-1:0] next_en(input logic [CH_W-1:0] cur,
                                                input logic [N_CH-1:0] en);
        logic [CH_W-1:0]  res;
        logic [CHX_W-1:0] cand;
        logic             found;
        res   = cur;
        found = 1'b0;
        for (int k = 1; k < N_CH; k++) begin
            cand = {1'b0, cur} + CHX_W'(k);
            if (cand >= N_CH_L) cand = cand - N_CH_L;
            if (!found && en[cand[CH_W-1:0]]) begin
                res   = cand[CH_W-1:0];
                found = 1'b1;
            end
        end
        return res;
    endfunction

    assign w_busy     = (r_timer != '0);
    assign w_rx_ok    = (12'(rx_count) + RX_NEED) <= RX_DEP;
    assign w_start    = reg_ch_en[r_ch_sel] & ~w_busy & ~tx_empty & (reg_word_num != 9'd0) & w_rx_ok;
    assign w_word_inc = r_word_cnt + 9'd1;
    assign w_rx_wr    = phy_miso_vld & (r_state == S_WORK) & (r_work_idx < WI_RXB) & ~reg_rst;
    assign w_sel_oh   = N_CH'(1) << r_ch_sel;

    always_comb begin
        w_state_nx    = r_state;
        w_ch_nx       = r_ch_sel;
        w_timer_nx    = w_busy ? r_timer - TMR_W'(1) : r_timer;
        w_word_nx     = r_word_cnt;
        w_widx_nx     = r_work_idx;
        w_chip_nx     = r_chip_idx;
        w_nop_nx      = r_nop_cnt;
        w_mosi_nx     = 1'b0;
        w_nonce_nx    = w_rx_wr & (r_work_idx == WI_NONCE) & (phy_miso_dat == 32'hbeafbeaf);
        w_nonce_ch_nx = w_nonce_nx ? r_ch_sel : r_nonce_ch;
        case (r_state)
            S_IDLE: begin
                if (reg_ch_en != '0 && !reg_ch_en[r_ch_sel]) begin
                    w_ch_nx = next_en(r_ch_sel, reg_ch_en);
                end else if (w_start) begin
                    w_state_nx = S_WORK;
                    // The start cycle is the first countdown cycle, so starts are exactly reg_timeout apart.
                    w_timer_nx = (reg_timeout == '0) ? '0 : reg_timeout - TMR_W'(1);
                    w_word_nx  = '0;
                    w_widx_nx  = '0;
                    w_chip_nx  = '0;
                    w_mosi_nx  = 1'b1;
                end
            end
            S_WORK: begin
                if (r_word_cnt == reg_word_num) begin
                    w_state_nx = S_NOP;
                    w_nop_nx   = '0;
                end else if (phy_miso_vld) begin
                    w_word_nx = w_word_inc;
                    if (r_work_idx == WI_LAST) begin
                        w_widx_nx = '0;
                        w_chip_nx = r_chip_idx + 4'd1;
                    end else begin
                        w_widx_nx = r_work_idx + WI_W'(1);
                    end
                    w_mosi_nx = (w_word_inc < reg_word_num);
                end
            end
            S_NOP: begin
                if (r_nop_cnt == NOP_LAST) begin
                    w_state_nx = S_IDLE;
                    w_nop_nx   = '0;
                    w_ch_nx    = next_en(r_ch_sel, reg_ch_en);
                end else begin
                    w_nop_nx = r_nop_cnt + NOP_W'(1);
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_ch_sel    <= '0;
            r_timer     <= '0;
            r_word_cnt  <= '0;
            r_work_idx  <= '0;
            r_chip_idx  <= '0;
            r_nop_cnt   <= '0;
            r_mosi_vld  <= 1'b0;
            r_nonce_hit <= 1'b0;
            r_nonce_ch  <= '0;
        end else if (reg_rst) begin
            r_state     <= S_IDLE;
            r_ch_sel    <= '0;
            r_timer     <= '0;
            r_word_cnt  <= '0;
            r_work_idx  <= '0;
            r_chip_idx  <= '0;
            r_nop_cnt   <= '0;
            r_mosi_vld  <= 1'b0;
            r_nonce_hit <= 1'b0;
            r_nonce_ch  <= '0;
        end else begin
            r_state     <= w_state_nx;
            r_ch_sel    <= w_ch_nx;
            r_timer     <= w_timer_nx;
            r_word_cnt  <= w_word_nx;
            r_work_idx  <= w_widx_nx;
            r_chip_idx  <= w_chip_nx;
            r_nop_cnt   <= w_nop_nx;
            r_mosi_vld  <= w_mosi_nx;
            r_nonce_hit <= w_nonce_nx;
            r_nonce_ch  <= w_nonce_ch_nx;
        end
    end

    // TX FIFO is first-word-fall-through: the word on tx_dout is the one being popped.
    assign phy_mosi_vld = r_mosi_vld & ~reg_rst;
    assign tx_rd_en     = r_mosi_vld & ~reg_rst;
    assign phy_mosi_dat = tx_dout;
    assign rx_wr_en     = w_rx_wr;
    assign rx_din       = (r_work_idx == WI_TAG) ?
                          {phy_miso_dat[31:16], 4'h1, r_chip_idx, 8'(r_ch_sel)} : phy_miso_dat;
    assign state        = r_state;
    assign busy         = w_busy;
    assign load         = ~w_sel_oh;
    assign miso_out     = miso_ch[r_ch_sel];
    assign miner_id     = r_ch_sel;
    assign chip_idx     = r_chip_idx;
    assign nonce_hit    = r_nonce_hit;
    assign nonce_ch     = r_nonce_ch;
endmodule

// File: tb/tb_api_ch_sched.sv
// Directed bench for api_ch_sched: a PHY responder task issues words and queues the expected
// RX writes and nonce hits; a negedge monitor pops and compares whenever the DUT produces them.
module tb_api_ch_sched;
    localparam int N_CH  = 10;
    localparam int CH_W  = 4;
    localparam int TMR_W = 28;

    logic             clk          = 1'b0;
    logic             rst          = 1'b1;
    logic             reg_rst      = 1'b0;
    logic [N_CH-1:0]  reg_ch_en    = '0;
    logic [8:0]       reg_word_num = '0;
    logic [TMR_W-1:0] reg_timeout  = '0;
    logic             tx_empty     = 1'b1;
    logic [31:0]      tx_dout      = 32'h7000_0000;
    logic [9:0]       rx_count     = '0;
    logic             phy_miso_vld = 1'b0;
    logic [31:0]      phy_miso_dat = '0;
    logic [N_CH-1:0]  miso_ch      = '0;
    logic [1:0]       state;
    logic             busy, tx_rd_en, rx_wr_en, phy_mosi_vld, miso_out, nonce_hit;
    logic [31:0]      rx_din, phy_mosi_dat;
    logic [N_CH-1:0]  load;
    logic [CH_W-1:0]  miner_id, nonce_ch;
    logic [3:0]       chip_idx;

    logic [31:0] exp_q[$];
    logic [3:0]  exp_nonce_q[$];
    logic [31:0] mon_exp;
    logic [3:0]  mon_nexp;
    int n_cmp = 0, n_bad = 0, nonce_seen = 0, seq = 0, cyc = 0;
    int s_a, s_b, s_c, s_d, fw;

    api_ch_sched dut (
        .clk(clk), .rst(rst), .reg_rst(reg_rst), .reg_ch_en(reg_ch_en),
        .reg_word_num(reg_word_num), .reg_timeout(reg_timeout), .state(state), .busy(busy),
        .tx_empty(tx_empty), .tx_rd_en(tx_rd_en), .tx_dout(tx_dout), .rx_wr_en(rx_wr_en),
        .rx_din(rx_din), .rx_count(rx_count), .phy_mosi_vld(phy_mosi_vld),
        .phy_mosi_dat(phy_mosi_dat), .phy_miso_vld(phy_miso_vld), .phy_miso_dat(phy_miso_dat),
        .load(load), .miso_ch(miso_ch), .miso_out(miso_out), .miner_id(miner_id),
        .chip_idx(chip_idx), .nonce_hit(nonce_hit), .nonce_ch(nonce_ch)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [N_CH-1:0] exp_load(input int ch);
        logic [N_CH-1:0] oh;
        oh = N_CH'(1) << ch;
        return ~oh;
    endfunction

    // scoreboard monitor
    always @(negedge clk) begin
        if (rx_wr_en) begin
            if (exp_q.size() == 0) begin
                check("rx_unexpected", rx_din, 32'h0);
                n_bad += (rx_din === 32'h0) ? 1 : 0;
            end else begin
                mon_exp = exp_q.pop_front();
                check("rx_din", rx_din, mon_exp);
            end
        end
        if (nonce_hit) begin
            nonce_seen++;
            if (exp_nonce_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL nonce_unexpected: got nonce_ch %h expected no hit", nonce_ch);
            end else begin
                mon_nexp = exp_nonce_q.pop_front();
                check("nonce_ch", 32'(nonce_ch), 32'(mon_nexp));
            end
        end
    end

    task automatic wait_mosi(input int budget, output int waited, output bit found);
        found  = 1'b0;
        waited = 0;
        while (!found && waited < budget) begin
            @(negedge clk);
            waited++;
            if (phy_mosi_vld) found = 1'b1;
        end
    endtask

    task automatic wait_idle(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (state == 2'd0) ok = 1'b1;
        end
        check(name, 32'(ok), 32'd1);
    endtask

    task automatic quiet(input int n, input string name);
        int act = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (tx_rd_en || rx_wr_en || phy_mosi_vld) act++;
        end
        check(name, 32'(act), 32'd0);
    endtask

    // PHY driver: answers each mosi word one cycle later; abort_mode 1 = reg_rst, 2 = async rst
    task automatic run_frame(input int ch, input int nw, input int inj, input int abort_at,
                             input int abort_mode, input bit hold,
                             output int start_cyc, output int first_wait);
        int w, widx, chip;
        bit f;
        logic [31:0] dat;
        start_cyc  = 0;
        first_wait = 0;
        miso_ch    = N_CH'(1) << ch;
        for (int k = 0; k < nw; k++) begin
            wait_mosi(1200, w, f);
            if (!f) begin
                n_cmp++;
                n_bad++;
                $display("FAIL mosi_timeout: ch %0d word %0d got no mosi expected one", ch, k);
                return;
            end
            if (k == 0) begin
                start_cyc  = cyc;
                first_wait = w;
                check("load_at_start", 32'(load), 32'(exp_load(ch)));
                check("miner_id", 32'(miner_id), 32'(ch));
                check("miso_out", 32'(miso_out), 32'd1);
            end
            check("tx_rd_en", 32'(tx_rd_en), 32'd1);
            check("mosi_dat", phy_mosi_dat, tx_dout);
            @(posedge clk); #1;
            tx_dout = tx_dout + 32'h11;
            if (k == 0 && hold) tx_empty = 1'b1;
            if (k == abort_at) begin
                if (abort_mode == 1) begin
                    reg_rst = 1'b1;
                    @(posedge clk); #1;
                    reg_rst = 1'b0;
                end else begin
                    #2 rst = 1'b1;
                    #1;
                    check("async_state", 32'(state), 32'd0);
                    check("async_load", 32'(load), 32'(exp_load(0)));
                    @(posedge clk); #1;
                    rst = 1'b0;
                end
                return;
            end
            seq++;
            dat  = (k == inj) ? 32'hbeafbeaf : (32'hA500_0000 ^ (32'(seq) * 32'h0001_0003));
            widx = k % 23;
            chip = (k / 23) % 16;
            phy_miso_vld = 1'b1;
            phy_miso_dat = dat;
            if (widx < 11) begin
                if (widx == 10) exp_q.push_back({dat[31:16], 4'h1, 4'(chip), 8'(ch)});
                else exp_q.push_back(dat);
                if (widx == 9 && dat == 32'hbeafbeaf) exp_nonce_q.push_back(4'(ch));
            end
            @(posedge clk); #1;
            phy_miso_vld = 1'b0;
        end
    endtask

    initial begin
        int stall;
        // reset
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_state", 32'(state), 32'd0);
        check("rst_load", 32'(load), 32'(exp_load(0)));
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_miner", 32'(miner_id), 32'd0);
        check("rst_chip", 32'(chip_idx), 32'd0);
        check("rst_nonce", 32'(nonce_hit), 32'd0);
        check("rst_txrd", 32'(tx_rd_en), 32'd0);

        // all enabled, 46 words on ch0: two chip slots of tagged captures
        @(posedge clk); #1;
        reg_ch_en    = '1;
        reg_word_num = 9'd46;
        tx_empty     = 1'b0;
        run_frame(0, 46, -1, -1, 0, 1'b1, s_a, fw);
        quiet(1, "no_extra_mosi");
        wait_idle("idle_after_f0");
        check("next_load", 32'(load), 32'h0000_03FD);
        check("next_miner", 32'(miner_id), 32'd1);

        // sparse mask: current ch1 disabled -> skip to 2 without starting
        @(posedge clk); #1;
        reg_ch_en    = 10'b1000000101;
        reg_word_num = 9'd12;
        tx_empty     = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check("skip_miner", 32'(miner_id), 32'd2);
        check("skip_no_start", 32'(state), 32'd0);
        run_frame(2, 12, -1, -1, 0, 1'b1, s_a, fw);
        wait_idle("idle_after_ch2");
        @(posedge clk); #1 tx_empty = 1'b0;
        run_frame(9, 12, -1, -1, 0, 1'b1, s_a, fw);
        wait_idle("idle_after_ch9");
        @(posedge clk); #1 tx_empty = 1'b0;
        run_frame(0, 12, -1, -1, 0, 1'b1, s_a, fw);
        wait_idle("idle_after_ch0");

        // RX space: 52 free < 55 stalls, 55 free starts on the next edge
        @(posedge clk); #1;
        rx_count = 10'd460;
        tx_empty = 1'b0;
        stall = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (state != 2'd0) stall++;
        end
        check("rx_full_stall", 32'(stall), 32'd0);
        @(posedge clk); #1 rx_count = 10'd457;
        run_frame(2, 12, -1, -1, 0, 1'b1, s_a, fw);
        check("rx_space_start_lat", 32'(fw), 32'd2);
        rx_count = 10'd0;
        wait_idle("idle_after_rx");

        // frame-rate timer: 1000-cycle spacing, then back-to-back with timeout 0
        @(posedge clk); #1;
        reg_ch_en    = '1;
        reg_timeout  = 28'd1000;
        reg_word_num = 9'd4;
        tx_empty     = 1'b0;
        run_frame(9, 4, -1, -1, 0, 1'b0, s_a, fw);
        check("busy_running", 32'(busy), 32'd1);
        run_frame(0, 4, -1, -1, 0, 1'b0, s_b, fw);
        check("timer_spacing", 32'(s_b - s_a), 32'd1000);
        reg_timeout = '0;
        run_frame(1, 4, -1, -1, 0, 1'b0, s_c, fw);
        run_frame(2, 4, -1, -1, 0, 1'b1, s_d, fw);
        check("b2b_spacing", 32'(s_d - s_c), 32'd25);
        wait_idle("idle_after_timer");

        // nonce on ch3: word 9 of chip 1 hits, word 8 does not
        @(posedge clk); #1;
        reg_ch_en    = 10'b0000001000;
        reg_word_num = 9'd46;
        tx_empty     = 1'b0;
        run_frame(3, 46, 32, -1, 0, 1'b1, s_a, fw);
        wait_idle("idle_after_nonce");
        @(posedge clk); #1 tx_empty = 1'b0;
        run_frame(3, 46, 31, -1, 0, 1'b1, s_a, fw);
        wait_idle("idle_after_nonce_miss");
        check("nonce_ch_hold", 32'(nonce_ch), 32'd3);

        // soft reset at word 10, then stray miso while idle must be ignored
        @(posedge clk); #1;
        reg_ch_en = '1;
        tx_empty  = 1'b0;
        run_frame(3, 46, -1, 10, 1, 1'b1, s_a, fw);
        @(negedge clk);
        check("srst_state", 32'(state), 32'd0);
        check("srst_load", 32'(load), 32'(exp_load(0)));
        @(posedge clk); #1;
        phy_miso_vld = 1'b1;
        phy_miso_dat = 32'h1234_5678;
        quiet(1, "stray_miso");
        @(posedge clk); #1 phy_miso_vld = 1'b0;
        quiet(20, "srst_quiet");

        // async reset at word 10 on ch1
        @(posedge clk); #1;
        reg_word_num = 9'd4;
        tx_empty     = 1'b0;
        run_frame(0, 4, -1, -1, 0, 1'b1, s_a, fw);
        wait_idle("idle_before_arst");
        @(posedge clk); #1;
        reg_word_num = 9'd46;
        tx_empty     = 1'b0;
        run_frame(1, 46, -1, 10, 2, 1'b1, s_a, fw);
        quiet(20, "arst_quiet");
        check("arst_miner", 32'(miner_id), 32'd0);

        repeat (5) @(negedge clk);
        check("rx_q_drained", 32'(exp_q.size()), 32'd0);
        check("nonce_q_drained", 32'(exp_nonce_q.size()), 32'd0);
        check("nonce_count", 32'(nonce_seen), 32'd1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
